// File: rtl/arb_pkg.sv
// Shared types and constants for the two-source round-robin arbiter.
package arb_pkg;

   localparam int DATA_W = 32;

   typedef enum logic {
      SRC_A = 1'b0,
      SRC_B = 1'b1
   } src_e;

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Producer/consumer handshake bundle around the arbiter.
interface mux2_rr_arbiter_if;
   import arb_pkg::*;

   logic              a_valid;
   logic [DATA_W-1:0] a_data;
   logic              a_ready;
   logic              b_valid;
   logic [DATA_W-1:0] b_data;
   logic              b_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_src;
   logic              out_ready;

   modport master (
      output a_valid, a_data,
      output b_valid, b_data,
      output out_ready,
      input  a_ready, b_ready,
      input  out_valid, out_data, out_src
   );

   modport slave (
      input  a_valid, a_data,
      input  b_valid, b_data,
      input  out_ready,
      output a_ready, b_ready,
      output out_valid, out_data, out_src
   );

endinterface

// File: rtl/mux2to1_32.sv
// 32-bit 2-to-1 select: sel=0 passes a, sel=1 passes b.
module mux2to1_32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        sel,
   output logic [31:0] y
);

   assign y = sel ? b : a;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter for two producers sharing one mux and a
// single registered output stage, with saturating grant counters.
module mux2_rr_arbiter
   import arb_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   mux2_rr_arbiter_if.slave bus,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   src_e              grant;
   src_e              last_grant;
   src_e              src_q;
   logic              valid_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] mux_y;
   logic              can_load;
   logic              xfer_a;
   logic              xfer_b;

   assign can_load = !valid_q || bus.out_ready;

   // Contention goes to whoever did not win the last transfer.
   always_comb begin
      grant = SRC_A;
      if (bus.a_valid && bus.b_valid) begin
         grant = (last_grant == SRC_A) ? SRC_B : SRC_A;
      end else if (bus.b_valid) begin
         grant = SRC_B;
      end
   end

   assign xfer_a = !rst && can_load && bus.a_valid
                   && (grant == SRC_A);
   assign xfer_b = !rst && can_load && bus.b_valid
                   && (grant == SRC_B);

   assign bus.a_ready = xfer_a;
   assign bus.b_ready = xfer_b;

   mux2to1_32 u_mux (
      .a   (bus.a_data),
      .b   (bus.b_data),
      .sel (grant),
      .y   (mux_y)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         data_q     <= '0;
         src_q      <= SRC_A;
         last_grant <= SRC_B;
      end else if (xfer_a || xfer_b) begin
         valid_q    <= 1'b1;
         data_q     <= mux_y;
         src_q      <= grant;
         last_grant <= grant;
      end else if (bus.out_ready) begin
         valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         cnt_a <= '0;
         cnt_b <= '0;
      end else begin
         if (xfer_a && cnt_a != CNT_MAX) begin
            cnt_a <= cnt_a + CNT_W'(1);
         end
         if (xfer_b && cnt_b != CNT_MAX) begin
            cnt_b <= cnt_b + CNT_W'(1);
         end
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.out_data  = data_q;
   assign bus.out_src   = src_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench: directed vector tables, reset corner cases
// and a randomized run against a cycle-level reference model.
module tb_mux2_rr_arbiter;

   localparam int CNT_W = 4;
   localparam int MAXC  = (1 << CNT_W) - 1;

   typedef struct {
      logic        av;
      logic [31:0] ad;
      logic        bv;
      logic [31:0] bd;
      logic        ordy;
      logic        clr;
      logic        e_ar;
      logic        e_br;
      logic        e_ov;
      logic [31:0] e_od;
      logic        e_src;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             cnt_clr;
   logic [CNT_W-1:0] cnt_a;
   logic [CNT_W-1:0] cnt_b;

   int n_cmp = 0;
   int n_bad = 0;

   vec_t vq[$];

   mux2_rr_arbiter_if bus ();

   mux2_rr_arbiter #(
      .CNT_W (CNT_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .cnt_clr (cnt_clr),
      .cnt_a   (cnt_a),
      .cnt_b   (cnt_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic av, input logic [31:0] ad,
                        input logic bv, input logic [31:0] bd,
                        input logic ordy, input logic clr);
      bus.a_valid   = av;
      bus.a_data    = ad;
      bus.b_valid   = bv;
      bus.b_data    = bd;
      bus.out_ready = ordy;
      cnt_clr       = clr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void add(
      input logic av, input logic [31:0] ad,
      input logic bv, input logic [31:0] bd,
      input logic ordy, input logic clr,
      input logic ear, input logic ebr,
      input logic eov, input logic [31:0] eod,
      input logic esrc);
      vq.push_back('{av, ad, bv, bd, ordy, clr,
                     ear, ebr, eov, eod, esrc});
   endfunction

   task automatic run_vecs(input string nm);
      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].av, vq[i].ad, vq[i].bv, vq[i].bd,
               vq[i].ordy, vq[i].clr);
         #3;
         chk($sformatf("%s[%0d].ready", nm, i),
             {62'd0, bus.a_ready, bus.b_ready},
             {62'd0, vq[i].e_ar, vq[i].e_br});
         tick();
         chk($sformatf("%s[%0d].out", nm, i),
             {30'd0, bus.out_valid, bus.out_src, bus.out_data},
             {30'd0, vq[i].e_ov, vq[i].e_src, vq[i].e_od});
      end
      vq.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(0, 0, 0, 0, 1, 0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Reference model state for the randomized run.
   bit          m_ov;
   logic [31:0] m_od;
   bit          m_src;
   bit          m_last;
   int          m_ca;
   int          m_cb;

   initial begin
      bit          pa, pb, ordy, clr, ld;
      logic [31:0] da, db;
      int          w;

      #1;
      do_reset();
      chk("reset.out",
          {31'd0, bus.out_valid, bus.out_src, bus.out_data},
          64'd0);
      chk("reset.cnt", {56'd0, cnt_a, cnt_b}, 64'd0);

      // A alone
      add(1, 32'h11, 0, 0, 1, 0, 1, 0, 1, 32'h11, 0);
      run_vecs("a_alone");
      chk("a_alone.cnt_a", 64'(cnt_a), 64'd1);

      // Continuous contention alternates starting with A
      do_reset();
      add(1, 32'hA0, 1, 32'hB0, 1, 0, 1, 0, 1, 32'hA0, 0);
      add(1, 32'hA1, 1, 32'hB0, 1, 0, 0, 1, 1, 32'hB0, 1);
      add(1, 32'hA1, 1, 32'hB1, 1, 0, 1, 0, 1, 32'hA1, 0);
      add(1, 32'hA2, 1, 32'hB1, 1, 0, 0, 1, 1, 32'hB1, 1);
      run_vecs("contend");
      chk("contend.cnt", {56'd0, cnt_a, cnt_b}, 64'h22);

      // Backpressure holds the word; A wins after release
      add(0, 0, 1, 32'hDEADBEEF, 1, 0,
          0, 1, 1, 32'hDEADBEEF, 1);
      for (int i = 0; i < 3; i++) begin
         add(1, 32'h1234, 1, 32'h5678, 0, 0,
             0, 0, 1, 32'hDEADBEEF, 1);
      end
      add(1, 32'h1234, 1, 32'h5678, 1, 0, 1, 0, 1, 32'h1234, 0);
      add(0, 0, 1, 32'h5678, 1, 0, 0, 1, 1, 32'h5678, 1);
      add(0, 0, 0, 0, 1, 1, 0, 0, 0, 32'h5678, 1);
      run_vecs("bp");

      // Back-to-back single source
      for (int i = 1; i <= 8; i++) begin
         add(0, 0, 1, 32'(i), 1, 0, 0, 1, 1, 32'(i), 1);
      end
      add(0, 0, 0, 0, 1, 1, 0, 0, 0, 32'd8, 1);
      run_vecs("stream");
      chk("stream.cnt_b_pre_clr", 64'(cnt_b), 64'd0);

      // Saturation, then clear beats a simultaneous increment
      for (int i = 0; i < 20; i++) begin
         add(1, 32'(i + 16), 0, 0, 1, 0, 1, 0, 1, 32'(i + 16), 0);
      end
      run_vecs("sat");
      chk("sat.cnt_a", 64'(cnt_a), 64'(MAXC));
      add(1, 32'h99, 0, 0, 1, 1, 1, 0, 1, 32'h99, 0);
      run_vecs("clr");
      chk("clr.cnt", {56'd0, cnt_a, cnt_b}, 64'd0);

      // Stream count check uses a fresh, uncleared stream
      for (int i = 1; i <= 8; i++) begin
         add(0, 0, 1, 32'(i), 1, 0, 0, 1, 1, 32'(i), 1);
      end
      run_vecs("stream2");
      chk("stream2.cnt_b", 64'(cnt_b), 64'd8);

      // Mid-stream reset drops the word in flight
      drive(1, 32'h77, 0, 0, 1, 0);
      tick();
      chk("mrst.pre", {63'd0, bus.out_valid}, 64'd1);
      rst = 1'b1;
      drive(1, 32'h78, 0, 0, 0, 0);
      #3;
      chk("mrst.ready", {62'd0, bus.a_ready, bus.b_ready}, 64'd0);
      tick();
      chk("mrst.out", {31'd0, bus.out_valid, bus.out_src,
          bus.out_data}, 64'd0);
      rst = 1'b0;
      drive(1, 32'h55, 1, 32'h66, 1, 0);
      #3;
      chk("mrst.grant", {62'd0, bus.a_ready, bus.b_ready}, 64'd2);
      tick();
      chk("mrst.first", {31'd0, bus.out_valid, bus.out_src,
          bus.out_data}, {31'd0, 1'b1, 1'b0, 32'h55});

      // Randomized run against the reference model
      do_reset();
      m_ov = 0; m_od = 0; m_src = 0; m_last = 1;
      m_ca = 0; m_cb = 0;
      pa = 0; pb = 0; da = 0; db = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!pa && $urandom_range(2) == 0) begin
            pa = 1; da = $urandom;
         end
         if (!pb && $urandom_range(2) == 0) begin
            pb = 1; db = $urandom;
         end
         ordy = ($urandom_range(3) != 0);
         clr  = ($urandom_range(39) == 0);
         drive(pa, da, pb, db, ordy, clr);
         ld = !m_ov || ordy;
         w = -1;
         if (ld && pa && pb) w = m_last ? 0 : 1;
         else if (ld && pa) w = 0;
         else if (ld && pb) w = 1;
         #3;
         chk("rnd.ready", {62'd0, bus.a_ready, bus.b_ready},
             {62'd0, w == 0, w == 1});
         tick();
         if (w >= 0) begin
            m_ov = 1;
            m_od = (w == 1) ? db : da;
            m_src = (w == 1);
            m_last = (w == 1);
            if (w == 0) begin
               pa = 0;
               if (m_ca < MAXC) m_ca++;
            end else begin
               pb = 0;
               if (m_cb < MAXC) m_cb++;
            end
         end else if (ordy) begin
            m_ov = 0;
         end
         if (clr) begin
            m_ca = 0; m_cb = 0;
         end
         chk("rnd.out", {31'd0, bus.out_valid, bus.out_src,
             bus.out_data}, {31'd0, m_ov, m_src, m_od});
         chk("rnd.cnt", {56'd0, cnt_a, cnt_b},
             {56'd0, 4'(m_ca), 4'(m_cb)});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
